freelist: RTL and testbench

FREELIST -- requirements
Module: freelist

---
 rtl/freelist_pkg.sv | 21 ++
 rtl/freelist_if.sv | 25 ++
 rtl/freelist_lane_compact.sv | 15 +
 rtl/freelist.sv | 99 +++++++++
 tb/tb_freelist.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freelist_pkg.sv
// Shared rename-core constants and the lane prefix-count helper used by the
// free list's lane compaction logic.
package freelist_pkg;

  localparam int CORE_WIDTH_REG = 7;
  localparam int CORE_WIDTH_BRM = 4;
  localparam int LANES          = 4;

  typedef logic [2:0] lane_cnt_t;

  // Number of set bits in mask[upto-1:0]; upto == LANES gives the total.
  function automatic lane_cnt_t prefix_count(input logic [LANES-1:0] mask, input int upto);
    lane_cnt_t c;
    c = '0;
    for (int j = 0; j < LANES; j++) begin
      if (j < upto && mask[j]) c = c + 3'd1;
    end
    return c;
  endfunction

endpackage

// File: rtl/freelist_if.sv
// Rename/commit side bundle of the physical register free list.
interface freelist_if import freelist_pkg::*; #(
  parameter int WIDTH_REG = CORE_WIDTH_REG
) ();

  logic [LANES-1:0]           i_alloc_mask;
  logic                       i_alloc_we;
  logic [LANES*WIDTH_REG-1:0] o_alloc_prd4x;
  logic                       o_alloc_rdy;
  logic [LANES*WIDTH_REG-1:0] i_com_prd4x;
  logic                       i_com_en;
  logic [WIDTH_REG:0]         o_count;
  logic                       o_overflow;

  modport master (
    output i_alloc_mask, i_alloc_we, i_com_prd4x, i_com_en,
    input  o_alloc_prd4x, o_alloc_rdy, o_count, o_overflow
  );

  modport slave (
    input  i_alloc_mask, i_alloc_we, i_com_prd4x, i_com_en,
    output o_alloc_prd4x, o_alloc_rdy, o_count, o_overflow
  );

endinterface

// File: rtl/freelist_lane_compact.sv
// Turns a 4-lane valid mask into per-lane buffer offsets and a total count.
module lane_compact import freelist_pkg::*; (
  input  logic [LANES-1:0]       valid,
  output lane_cnt_t [LANES-1:0]  offset,
  output lane_cnt_t              total
);

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      offset[k] = prefix_count(valid, k);
    end
    total = prefix_count(valid, LANES);
  end

endmodule

// File: rtl/freelist.sv
// Circular-buffer free list of physical register tags: up to four compacted
// allocations and four releases per cycle, with a sticky overflow flag.
module freelist import freelist_pkg::*; #(
  parameter int WIDTH_REG = CORE_WIDTH_REG,
  parameter int NARCH     = 32
) (
  input logic       i_clk,
  input logic       i_rst_n,
  freelist_if.slave bus
);

  localparam int SIZE = 1 << WIDTH_REG;
  localparam int CW   = WIDTH_REG + 2;

  typedef logic [WIDTH_REG-1:0] tag_t;

  tag_t               mem [SIZE];
  tag_t               head;
  tag_t               tail;
  logic [WIDTH_REG:0] count;
  logic               overflow;

  tag_t                  com_tag [LANES];
  logic [LANES-1:0]      rel_valid;
  lane_cnt_t [LANES-1:0] pop_off;
  lane_cnt_t [LANES-1:0] rel_off;
  lane_cnt_t             pop_n;
  lane_cnt_t             rel_n;
  logic                  rdy;
  logic                  pop_fire;
  logic                  rel_ok;
  logic [CW-1:0]         pop_amt;
  logic [CW-1:0]         sum;
  logic [WIDTH_REG:0]    count_next;
  tag_t [LANES-1:0]      prd;

  lane_compact u_alloc_compact (
    .valid  (bus.i_alloc_mask),
    .offset (pop_off),
    .total  (pop_n)
  );

  lane_compact u_rel_compact (
    .valid  (rel_valid),
    .offset (rel_off),
    .total  (rel_n)
  );

  // Tag 0 marks an unused commit lane and is never returned to the pool.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      com_tag[k]   = bus.i_com_prd4x[k*WIDTH_REG +: WIDTH_REG];
      rel_valid[k] = bus.i_com_en && (com_tag[k] != '0);
    end
  end

  assign rdy        = (count >= (WIDTH_REG+1)'(pop_n));
  assign pop_fire   = bus.i_alloc_we && rdy;
  assign pop_amt    = pop_fire ? CW'(pop_n) : '0;
  assign sum        = CW'(count) - pop_amt + CW'(rel_n);
  assign rel_ok     = (sum <= CW'(SIZE));
  assign count_next = rel_ok ? sum[WIDTH_REG:0] : (count - pop_amt[WIDTH_REG:0]);

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prd[k] = bus.i_alloc_mask[k] ? mem[head + tag_t'(pop_off[k])] : '0;
    end
  end

  assign bus.o_alloc_prd4x = prd;
  assign bus.o_alloc_rdy   = rdy;
  assign bus.o_count       = count;
  assign bus.o_overflow    = overflow;

  // An over-capacity release is dropped whole; the pop side still proceeds.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      head     <= '0;
      tail     <= tag_t'(SIZE - NARCH);
      count    <= (WIDTH_REG+1)'(SIZE - NARCH);
      overflow <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        mem[i] <= (i < SIZE - NARCH) ? tag_t'(NARCH + i) : '0;
      end
    end else begin
      head  <= head + tag_t'(pop_amt);
      count <= count_next;
      if (rel_ok) begin
        tail <= tail + tag_t'(rel_n);
        for (int k = 0; k < LANES; k++) begin
          if (rel_valid[k]) mem[tail + tag_t'(rel_off[k])] <= com_tag[k];
        end
      end else begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freelist.sv
// Scoreboard bench for the free list: a FIFO reference model predicts tags,
// counts, readiness and the overflow flag cycle by cycle.
module tb_freelist;
  import freelist_pkg::*;

  localparam int W     = 7;
  localparam int NARCH = 32;
  localparam int SIZE  = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  freelist_if #(.WIDTH_REG(W)) fl_if ();

  freelist #(.WIDTH_REG(W), .NARCH(NARCH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (fl_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int free_q[$];
  int exp_q[$];
  bit m_ovf;

  function automatic logic [W-1:0] lane(input int k);
    return fl_if.o_alloc_prd4x[k*W +: W];
  endfunction

  function automatic int popc(input logic [3:0] m);
    int c;
    c = 0;
    for (int j = 0; j < 4; j++) if (m[j]) c++;
    return c;
  endfunction

  task automatic drive(input logic [3:0] mask, input logic we,
                       input int c0, input int c1, input int c2, input int c3,
                       input logic en);
    fl_if.i_alloc_mask = mask;
    fl_if.i_alloc_we   = we;
    fl_if.i_com_prd4x  = {W'(c3), W'(c2), W'(c1), W'(c0)};
    fl_if.i_com_en     = en;
  endtask

  // Expected lane outputs for the currently driven mask go to the scoreboard.
  task automatic push_expected(input logic [3:0] mask);
    int idx;
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        exp_q.push_back(free_q[idx]);
        idx++;
      end else begin
        exp_q.push_back(0);
      end
    end
  endtask

  task automatic model_step();
    int npop;
    int t;
    int rel[$];
    npop = popc(fl_if.i_alloc_mask);
    if (!(fl_if.i_alloc_we && free_q.size() >= npop)) npop = 0;
    if (fl_if.i_com_en) begin
      for (int k = 0; k < 4; k++) begin
        t = int'(fl_if.i_com_prd4x[k*W +: W]);
        if (t != 0) rel.push_back(t);
      end
    end
    if (free_q.size() - npop + rel.size() > SIZE) begin
      m_ovf = 1'b1;
      rel.delete();
    end
    repeat (npop) void'(free_q.pop_front());
    foreach (rel[i]) free_q.push_back(rel[i]);
  endtask

  task automatic model_reset();
    free_q.delete();
    exp_q.delete();
    for (int i = NARCH; i < SIZE; i++) free_q.push_back(i);
    m_ovf = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(4'b0000, 1'b0, 0, 0, 0, 0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    int e;
    apply_reset();
    drive(4'b1111, 1'b0, 0, 0, 0, 0, 1'b0);
    #1;
    n_cmp++;
    if (fl_if.o_count !== 8'd96) begin
      n_bad++; $display("FAIL reset_count got %0d want 96", fl_if.o_count);
    end
    n_cmp++;
    if (fl_if.o_alloc_rdy !== 1'b1) begin
      n_bad++; $display("FAIL reset_rdy got %b want 1", fl_if.o_alloc_rdy);
    end
    n_cmp++;
    if (fl_if.o_overflow !== 1'b0) begin
      n_bad++; $display("FAIL reset_overflow got %b want 0", fl_if.o_overflow);
    end
    push_expected(4'b1111);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (lane(k) !== W'(NARCH + k) || lane(k) !== W'(e)) begin
        n_bad++; $display("FAIL reset_lane%0d got %0d want %0d", k, lane(k), NARCH + k);
      end
    end
  endtask

  task automatic test_compact();
    int e;
    drive(4'b1011, 1'b1, 0, 0, 0, 0, 1'b0);
    #1;
    push_expected(4'b1011);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (lane(k) !== W'(e)) begin
        n_bad++; $display("FAIL compact_lane%0d got %0d want %0d", k, lane(k), e);
      end
    end
    tick();
    drive(4'b0001, 1'b0, 0, 0, 0, 0, 1'b0);
    #1;
    n_cmp++;
    if (fl_if.o_count !== 8'd93) begin
      n_bad++; $display("FAIL compact_count got %0d want 93", fl_if.o_count);
    end
    n_cmp++;
    if (lane(0) !== 7'd35) begin
      n_bad++; $display("FAIL compact_next_head got %0d want 35", lane(0));
    end
  endtask

  task automatic test_empty();
    int e;
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      drive(4'b1111, 1'b1, 0, 0, 0, 0, 1'b0);
      #1;
      push_expected(4'b1111);
      for (int k = 0; k < 4; k++) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (lane(k) !== W'(e)) begin
          n_bad++; $display("FAIL drain%0d_lane%0d got %0d want %0d", i, k, lane(k), e);
        end
      end
      tick();
    end
    drive(4'b0001, 1'b1, 0, 0, 0, 0, 1'b0);
    #1;
    n_cmp++;
    if (fl_if.o_count !== 8'd0) begin
      n_bad++; $display("FAIL empty_count got %0d want 0", fl_if.o_count);
    end
    n_cmp++;
    if (fl_if.o_alloc_rdy !== 1'b0) begin
      n_bad++; $display("FAIL empty_rdy got %b want 0", fl_if.o_alloc_rdy);
    end
    tick();
    n_cmp++;
    if (fl_if.o_count !== 8'd0) begin
      n_bad++; $display("FAIL empty_ignored_we got %0d want 0", fl_if.o_count);
    end
    drive(4'b0000, 1'b1, 0, 0, 0, 0, 1'b0);
    #1;
    n_cmp++;
    if (fl_if.o_alloc_rdy !== 1'b1) begin
      n_bad++; $display("FAIL empty_mask0_rdy got %b want 1", fl_if.o_alloc_rdy);
    end
  endtask

  task automatic test_release();
    int e;
    drive(4'b0011, 1'b1, 5, 0, 9, 0, 1'b1);
    #1;
    n_cmp++;
    if (fl_if.o_alloc_rdy !== 1'b0) begin
      n_bad++; $display("FAIL release_same_cycle_rdy got %b want 0", fl_if.o_alloc_rdy);
    end
    tick();
    drive(4'b0011, 1'b1, 0, 0, 0, 0, 1'b0);
    #1;
    n_cmp++;
    if (fl_if.o_count !== 8'd2) begin
      n_bad++; $display("FAIL release_count got %0d want 2", fl_if.o_count);
    end
    push_expected(4'b0011);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (lane(k) !== W'(e)) begin
        n_bad++; $display("FAIL release_lane%0d got %0d want %0d", k, lane(k), e);
      end
    end
    tick();
  endtask

  task automatic test_swap_wrap();
    int e;
    int t[4];
    drive(4'b0000, 1'b0, 10, 11, 12, 13, 1'b1);
    tick();
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) t[k] = 1 + ((13 + 4*i + k) % 127);
      drive(4'b1111, 1'b1, t[0], t[1], t[2], t[3], 1'b1);
      #1;
      push_expected(4'b1111);
      for (int k = 0; k < 4; k++) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (lane(k) !== W'(e)) begin
          n_bad++; $display("FAIL swap%0d_lane%0d got %0d want %0d", i, k, lane(k), e);
        end
      end
      tick();
      n_cmp++;
      if (fl_if.o_count !== 8'd4) begin
        n_bad++; $display("FAIL swap%0d_count got %0d want 4", i, fl_if.o_count);
      end
    end
  endtask

  task automatic test_random();
    int e;
    logic [3:0] m;
    logic exp_rdy;
    for (int i = 0; i < 80; i++) begin
      m = 4'($urandom_range(0, 15));
      drive(m, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
            ($urandom_range(0, 2) == 0));
      #1;
      exp_rdy = (free_q.size() >= popc(m));
      n_cmp++;
      if (fl_if.o_count !== 8'(free_q.size()) || fl_if.o_alloc_rdy !== exp_rdy) begin
        n_bad++; $display("FAIL rand%0d_state count %0d rdy %b want %0d %b",
                          i, fl_if.o_count, fl_if.o_alloc_rdy, free_q.size(), exp_rdy);
      end
      if (exp_rdy) begin
        push_expected(m);
        for (int k = 0; k < 4; k++) begin
          e = exp_q.pop_front();
          n_cmp++;
          if (lane(k) !== W'(e)) begin
            n_bad++; $display("FAIL rand%0d_lane%0d got %0d want %0d", i, k, lane(k), e);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_overflow_reset();
    int e;
    apply_reset();
    for (int g = 0; g < 7; g++) begin
      drive(4'b0000, 1'b0, 4*g+1, 4*g+2, 4*g+3, 4*g+4, 1'b1);
      tick();
    end
    drive(4'b0000, 1'b0, 29, 30, 0, 0, 1'b1);
    tick();
    n_cmp++;
    if (fl_if.o_count !== 8'd126) begin
      n_bad++; $display("FAIL fill_count got %0d want 126", fl_if.o_count);
    end
    drive(4'b0000, 1'b0, 1, 2, 3, 4, 1'b1);
    #1;
    n_cmp++;
    if (fl_if.o_overflow !== 1'b0) begin
      n_bad++; $display("FAIL pre_overflow got %b want 0", fl_if.o_overflow);
    end
    tick();
    n_cmp++;
    if (fl_if.o_overflow !== 1'b1 || fl_if.o_count !== 8'd126) begin
      n_bad++; $display("FAIL overflow ovf %b count %0d want 1 126", fl_if.o_overflow, fl_if.o_count);
    end
    drive(4'b1111, 1'b0, 0, 0, 0, 0, 1'b0);
    #1;
    push_expected(4'b1111);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (lane(k) !== W'(e)) begin
        n_bad++; $display("FAIL post_overflow_lane%0d got %0d want %0d", k, lane(k), e);
      end
    end
    tick();
    n_cmp++;
    if (fl_if.o_overflow !== 1'b1) begin
      n_bad++; $display("FAIL overflow_sticky got %b want 1", fl_if.o_overflow);
    end
    drive(4'b1111, 1'b1, 5, 6, 7, 8, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive(4'b1111, 1'b0, 0, 0, 0, 0, 1'b0);
    #1;
    n_cmp++;
    if (fl_if.o_count !== 8'd96 || fl_if.o_overflow !== 1'b0 || fl_if.o_alloc_rdy !== 1'b1) begin
      n_bad++; $display("FAIL midreset_state count %0d ovf %b rdy %b want 96 0 1",
                        fl_if.o_count, fl_if.o_overflow, fl_if.o_alloc_rdy);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (lane(k) !== W'(NARCH + k)) begin
        n_bad++; $display("FAIL midreset_lane%0d got %0d want %0d", k, lane(k), NARCH + k);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(4'b0000, 1'b0, 0, 0, 0, 0, 1'b0);
    test_reset();
    test_compact();
    test_empty();
    test_release();
    test_swap_wrap();
    test_random();
    test_overflow_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
